clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Mode/set-sequencing controller for the clock display path.
- Turns debounced single-cycle button pulses into the display's mode_date and set_* select lines.
- Issues field-tagged increment/decrement pulses to the time/date counters and holds those counters while a field is being edited.
- Returns to run mode automatically after an inactivity timeout measured in 1 Hz ticks.

Parameters:
- TIMEOUT_S, 30, seconds of button inactivity in an edit state before auto-exit to run; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick_1hz  in  1  one-clk pulse per second, clk domain
- btn_mode  in  1  debounced one-clk pulse: toggle time/date view, or abort edit
- btn_set  in  1  debounced one-clk pulse: enter edit / advance field
- btn_inc  in  1  debounced one-clk pulse: increment selected field
- btn_dec  in  1  debounced one-clk pulse: decrement selected field
- mode_date  out  1  0 = time view, 1 = date view
- set_sec, set_min, set_hour, set_day, set_month, set_year  out  1 each  one-hot edit selects, all 0 in run
- adj_inc  out  1  one-clk increment strobe
- adj_dec  out  1  one-clk decrement strobe
- adj_field  out  3  field for adj_*: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year
- hold_time  out  1  freeze the sec/min/hour counters
- hold_date  out  1  freeze the day/month/year counters

Behaviour:
- **States:** RUN_TIME, RUN_DATE, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MONTH, SET_YEAR.
- **Reset:** state RUN_TIME, idle counter 0. All outputs 0: mode_date 0, set_* 0, adj_inc 0, adj_dec 0, adj_field 0, hold_* 0.
- **Output timing:** all outputs registered; one clk latency from button pulse to output change.
- **Decodes:**
  - mode_date = 1 in RUN_DATE, SET_DAY, SET_MONTH, SET_YEAR.
  - set_x = 1 only in SET_X.
  - hold_time = 1 in SET_SEC, SET_MIN, SET_HOUR.
  - hold_date = 1 in SET_DAY, SET_MONTH, SET_YEAR.
- **Per-cycle priority:** rst > btn_mode > btn_set > timeout > inc/dec.
- **Run-state transitions:**
  - RUN_TIME: btn_mode -> RUN_DATE; btn_set -> SET_SEC.
  - RUN_DATE: btn_mode -> RUN_TIME; btn_set -> SET_DAY.
  - btn_inc and btn_dec are ignored in run states.
- **Edit-state transitions:**
  - btn_set advances SET_SEC -> SET_MIN -> SET_HOUR -> RUN_TIME.
  - btn_set advances SET_DAY -> SET_MONTH -> SET_YEAR -> RUN_DATE.
  - btn_mode in any edit state aborts to the run state of the same view; values already adjusted are kept.
- **Adjust strobes:**
  - In an edit state with no btn_mode/btn_set that cycle: btn_inc alone -> adj_inc = 1 for exactly one clk next cycle; btn_dec alone likewise for adj_dec.
  - adj_field = code of the current field, registered with the strobe.
  - btn_inc and btn_dec together -> no strobe.
  - adj_inc and adj_dec are never both 1.
  - adj_field holds its last value when no strobe is active.
- **Timeout:**
  - Idle counter is width clog2(TIMEOUT_S+1) and saturates.
  - Cleared on entry to any edit state and on any button pulse.
  - Increments on tick_1hz while in an edit state.
  - When the counter reaches TIMEOUT_S with tick_1hz, next state is the matching run state.
  - Counter is held at 0 in run states.
- **Simultaneous tick and button:** a button pulse and tick_1hz in the same cycle -> button wins and the counter clears.
- **Reset mid-edit:** rst returns to RUN_TIME and drops hold_* the next clk.
- **Range handling:** wrap-around/range limits of fields are the counters' job; this block never saturates values.

Decomposition:
- Shared package `clock_pkg` holds:
  - state enum,
  - FIELD_SEC..FIELD_YEAR codes 0..5, matching set_* bit order,
  - FIELD_W = 3.
- A sub-module `idle_timer` (TIMEOUT_S, clear, tick, en -> expired) is natural.
- The FSM and output decode stay in the top.

Test Plan:
- Reset, then btn_mode pulse -> mode_date = 1 one clk later; second btn_mode -> mode_date = 0; set_* and hold_* stay 0.
- RUN_TIME, btn_set x4 -> set_sec, then set_min, then set_hour, then all 0; hold_time = 1 during the three edit states.
- In SET_MIN, btn_inc -> adj_inc = 1 for 1 clk with adj_field = 1.
- In SET_YEAR, btn_dec -> adj_dec = 1 with adj_field = 5.
- btn_inc and btn_dec in the same cycle -> no strobe.
- TIMEOUT_S = 3, in SET_DAY with no buttons, 3 tick_1hz -> state RUN_DATE after the 3rd tick; with a btn_inc between ticks 2 and 3, exit occurs only after 3 further ticks.
- btn_set and btn_mode together in SET_HOUR -> RUN_TIME, no advance.
- rst asserted in SET_MONTH -> all outputs 0 next clk.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock set/mode controller.
//   state_t      : controller states (two run views, six edit fields)
//   FIELD_*      : adj_field codes, same order as the set_* select bits
//   FIELD_W      : width of adj_field
//   is_edit, is_date_view, field_of : small state decode helpers
package clock_pkg;

    localparam int FIELD_W = 3;

    localparam logic [FIELD_W-1:0] FIELD_SEC   = 3'd0;
    localparam logic [FIELD_W-1:0] FIELD_MIN   = 3'd1;
    localparam logic [FIELD_W-1:0] FIELD_HOUR  = 3'd2;
    localparam logic [FIELD_W-1:0] FIELD_DAY   = 3'd3;
    localparam logic [FIELD_W-1:0] FIELD_MONTH = 3'd4;
    localparam logic [FIELD_W-1:0] FIELD_YEAR  = 3'd5;

    typedef enum logic [2:0] {
        RUN_TIME,
        RUN_DATE,
        SET_SEC,
        SET_MIN,
        SET_HOUR,
        SET_DAY,
        SET_MONTH,
        SET_YEAR
    } state_t;

    function automatic logic is_edit(state_t s);
        return (s != RUN_TIME) && (s != RUN_DATE);
    endfunction

    // Date view covers the date run state and the three date edit fields.
    function automatic logic is_date_view(state_t s);
        return (s == RUN_DATE) || (s == SET_DAY) || (s == SET_MONTH) || (s == SET_YEAR);
    endfunction

    function automatic logic [FIELD_W-1:0] field_of(state_t s);
        logic [FIELD_W-1:0] f;
        case (s)
            SET_MIN:   f = FIELD_MIN;
            SET_HOUR:  f = FIELD_HOUR;
            SET_DAY:   f = FIELD_DAY;
            SET_MONTH: f = FIELD_MONTH;
            SET_YEAR:  f = FIELD_YEAR;
            default:   f = FIELD_SEC;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity timer for the edit states.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : any button pulse this cycle; restarts the count
//   tick     : 1 Hz pulse
//   en       : controller is in an edit state; count is held at 0 otherwise
//   expired  : combinational, high in the cycle whose tick completes
//              TIMEOUT_S idle seconds (never high when TIMEOUT_S == 0)
module idle_timer #(
    parameter int TIMEOUT_S = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic en,
    output logic expired
);

    localparam int W      = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
    localparam int TOP_I  = (TIMEOUT_S < 1) ? 0 : TIMEOUT_S;
    localparam int LAST_I = (TIMEOUT_S < 1) ? 0 : TIMEOUT_S - 1;
    localparam logic [W-1:0] TOP  = TOP_I[W-1:0];
    localparam logic [W-1:0] LAST = LAST_I[W-1:0];

    logic [W-1:0] cnt;

    // A button in the same cycle as a tick wins: the count restarts instead.
    assign expired = (TIMEOUT_S > 0) && en && tick && !clear && (cnt >= LAST);

    always_ff @(posedge clk) begin
        if (rst || !en || clear) begin
            cnt <= '0;
        end else if (tick && (cnt != TOP)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode / set sequencing controller for the clock display path.
//   clk, rst          : system clock, synchronous active-high reset
//   tick_1hz          : one-clk pulse per second
//   btn_mode/set/inc/dec : debounced one-clk button pulses
//   mode_date         : 0 time view, 1 date view
//   set_sec..set_year : one-hot edit field selects, all 0 in run states
//   adj_inc, adj_dec  : one-clk adjust strobes, tagged with adj_field
//   hold_time/date    : freeze the counters of the field group being edited
//   dbg_state         : current controller state, for observation only
// All outputs are registered and follow the button pulse by one clk.
// Priority within a cycle: rst > btn_mode > btn_set > timeout > inc/dec.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               btn_mode,
    input  logic               btn_set,
    input  logic               btn_inc,
    input  logic               btn_dec,
    output logic               mode_date,
    output logic               set_sec,
    output logic               set_min,
    output logic               set_hour,
    output logic               set_day,
    output logic               set_month,
    output logic               set_year,
    output logic               adj_inc,
    output logic               adj_dec,
    output logic [FIELD_W-1:0] adj_field,
    output logic               hold_time,
    output logic               hold_date,
    output state_t             dbg_state
);

    state_t state;
    state_t next_state;
    logic   expired;
    logic   any_btn;
    logic   strobe_ok;

    // Entry to an edit state is always caused by btn_set, so clearing on any
    // button also covers "clear on entry" without a path through next_state.
    assign any_btn = btn_mode | btn_set | btn_inc | btn_dec;

    idle_timer #(.TIMEOUT_S(TIMEOUT_S)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (any_btn),
        .tick    (tick_1hz),
        .en      (is_edit(state)),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            RUN_TIME: begin
                if (btn_mode)     next_state = RUN_DATE;
                else if (btn_set) next_state = SET_SEC;
            end
            RUN_DATE: begin
                if (btn_mode)     next_state = RUN_TIME;
                else if (btn_set) next_state = SET_DAY;
            end
            SET_SEC: begin
                if (btn_mode || expired) next_state = RUN_TIME;
                else if (btn_set)        next_state = SET_MIN;
            end
            SET_MIN: begin
                if (btn_mode || expired) next_state = RUN_TIME;
                else if (btn_set)        next_state = SET_HOUR;
            end
            SET_HOUR: begin
                if (btn_mode || btn_set || expired) next_state = RUN_TIME;
            end
            SET_DAY: begin
                if (btn_mode || expired) next_state = RUN_DATE;
                else if (btn_set)        next_state = SET_MONTH;
            end
            SET_MONTH: begin
                if (btn_mode || expired) next_state = RUN_DATE;
                else if (btn_set)        next_state = SET_YEAR;
            end
            SET_YEAR: begin
                if (btn_mode || btn_set || expired) next_state = RUN_DATE;
            end
            default: next_state = RUN_TIME;
        endcase
    end

    // inc/dec only act when nothing of higher priority claimed the cycle.
    assign strobe_ok = is_edit(state) && !btn_mode && !btn_set && !expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN_TIME;
            mode_date <= 1'b0;
            set_sec   <= 1'b0;
            set_min   <= 1'b0;
            set_hour  <= 1'b0;
            set_day   <= 1'b0;
            set_month <= 1'b0;
            set_year  <= 1'b0;
            adj_inc   <= 1'b0;
            adj_dec   <= 1'b0;
            adj_field <= '0;
            hold_time <= 1'b0;
            hold_date <= 1'b0;
        end else begin
            state     <= next_state;
            mode_date <= is_date_view(next_state);
            set_sec   <= (next_state == SET_SEC);
            set_min   <= (next_state == SET_MIN);
            set_hour  <= (next_state == SET_HOUR);
            set_day   <= (next_state == SET_DAY);
            set_month <= (next_state == SET_MONTH);
            set_year  <= (next_state == SET_YEAR);
            hold_time <= (next_state == SET_SEC) || (next_state == SET_MIN) ||
                         (next_state == SET_HOUR);
            hold_date <= (next_state == SET_DAY) || (next_state == SET_MONTH) ||
                         (next_state == SET_YEAR);
            adj_inc   <= strobe_ok && btn_inc && !btn_dec;
            adj_dec   <= strobe_ok && btn_dec && !btn_inc;
            // adj_field keeps its last value between strobes.
            if (strobe_ok && (btn_inc ^ btn_dec)) begin
                adj_field <= field_of(state);
            end
        end
    end

    assign dbg_state = state;

endmodule
